// File: rtl/calc_bcd_param.sv
// Keypad-driven decimal calculator: iterative add/sub/mul/div, double-dabble
// binary-to-BCD conversion and digit-serial output to the display driver.
//
// state    | meaning
// ENTRY_A  | building operand A, or holding a chained result
// ENTRY_B  | operator latched, building operand B
// COMPUTE  | iterative arithmetic on A and B
// CONVERT  | binary result to BCD, one shift per cycle
// EMIT     | streaming result digits, most significant first
// ERR      | overflow, divide by zero or too many digits; waits for clear
module calc_bcd_param #(
    parameter int MAX_DIGITS = 8,
    parameter int WIDTH      = 32,
    parameter int POS_W      = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    output logic [1:0]       status,
    output logic [POS_W-1:0] pos,
    output logic [3:0]       dig,
    output logic             dig_valid,
    output logic             neg
);
    localparam int CW  = POS_W + 1;
    localparam int CYW = $clog2(WIDTH + 1);
    localparam int BW  = 4 * MAX_DIGITS;
    localparam int RW  = 2 * WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [RW-1:0] LIMIT   = RW'(10 ** MAX_DIGITS - 1);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {ENTRY_A, ENTRY_B, COMPUTE, CONVERT, EMIT, ERR} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, mb_q, mb_d, rem_q, rem_d, bin_q, bin_d;
    logic [CW-1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, n_q, n_d, emit_idx_q, emit_idx_d;
    logic [1:0]       op_q, op_d;
    logic             chained_q, chained_d, neg_q, neg_d, dig_valid_q, dig_valid_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [3:0]       dig_q, dig_d;
    logic [RW-1:0]    acc_q, acc_d, mc_q, mc_d;
    logic [CYW-1:0]   cyc_q, cyc_d;
    logic [BW-1:0]    bcd_q, bcd_d;

    logic             is_b, wr_cur, div_ge, a_ge_b;
    logic [WIDTH-1:0] cur_val, new_val, div_rem_n, div_q_n, bin_n;
    logic [CW-1:0]    cur_cnt, new_cnt, conv_n;
    logic [WIDTH:0]   rem_sh;
    logic [RW-1:0]    mul_acc_n, res;
    logic [BW-1:0]    bcd_adj, bcd_n;
    logic [3:0]       conv_top, emit_dig;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        bin_d       = bin_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        n_d         = n_q;
        emit_idx_d  = emit_idx_q;
        op_d        = op_q;
        chained_d   = chained_q;
        neg_d       = neg_q;
        pos_d       = pos_q;
        dig_d       = dig_q;
        dig_valid_d = 1'b0;
        acc_d       = acc_q;
        mc_d        = mc_q;
        cyc_d       = cyc_q;
        bcd_d       = bcd_q;

        is_b    = (state_q == ENTRY_B);
        cur_val = is_b ? b_q : a_q;
        cur_cnt = is_b ? b_cnt_q : a_cnt_q;
        wr_cur  = 1'b0;
        new_val = cur_val;
        new_cnt = cur_cnt;

        mul_acc_n = mb_q[0] ? acc_q + mc_q : acc_q;
        rem_sh    = {rem_q, mb_q[WIDTH-1]};
        div_ge    = (rem_sh >= {1'b0, b_q});
        div_rem_n = div_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        div_q_n   = {mb_q[WIDTH-2:0], div_ge};
        a_ge_b    = (a_q >= b_q);

        case (op_q)
            OP_ADD:  res = RW'(a_q) + RW'(b_q);
            OP_SUB:  res = a_ge_b ? RW'(a_q - b_q) : RW'(b_q - a_q);
            OP_MUL:  res = mul_acc_n;
            default: res = RW'(div_q_n);
        endcase

        bcd_adj = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        {bcd_n, bin_n} = {bcd_adj, bin_q} << 1;

        // A zero result still shows one digit.
        conv_n = CW'(1);
        for (int i = 1; i < MAX_DIGITS; i++) begin
            if (bcd_n[4*i +: 4] != 4'd0) conv_n = CW'(i + 1);
        end
        conv_top = bcd_n[3:0];
        emit_dig = bcd_q[3:0];
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (CW'(i + 1) == conv_n)     conv_top = bcd_n[4*i +: 4];
            if (CW'(i + 1) == emit_idx_q) emit_dig = bcd_q[4*i +: 4];
        end

        case (state_q)
            ENTRY_A, ENTRY_B: begin
                if (cmd_valid) begin
                    neg_d = 1'b0;
                    if (cmd <= 4'd9) begin
                        if (!is_b && chained_q) begin
                            wr_cur      = 1'b1;
                            new_val     = WIDTH'(cmd);
                            new_cnt     = CW'(1);
                            chained_d   = 1'b0;
                            pos_d       = '0;
                            dig_d       = cmd;
                            dig_valid_d = 1'b1;
                        end else if (cur_cnt == MAX_CNT) begin
                            state_d = ERR;
                            pos_d   = '0;
                        end else begin
                            wr_cur      = 1'b1;
                            new_val     = cur_val * WIDTH'(10) + WIDTH'(cmd);
                            new_cnt     = cur_cnt + CW'(1);
                            chained_d   = 1'b0;
                            pos_d       = cur_cnt[POS_W-1:0];
                            dig_d       = cmd;
                            dig_valid_d = 1'b1;
                        end
                    end else if (cmd <= 4'hD) begin
                        if (!is_b) begin
                            op_d      = cmd[1:0];
                            b_d       = '0;
                            b_cnt_d   = '0;
                            chained_d = 1'b0;
                            state_d   = ENTRY_B;
                        end else if (b_cnt_q == '0) begin
                            op_d = cmd[1:0];
                        end
                    end else if (cmd == 4'hE) begin
                        if (is_b && b_cnt_q != '0) begin
                            state_d = COMPUTE;
                            acc_d   = '0;
                            rem_d   = '0;
                            mc_d    = RW'(a_q);
                            mb_d    = (op_q == OP_DIV) ? a_q : b_q;
                            cyc_d   = op_q[1] ? '0 : CYW'(WIDTH - 1);
                        end
                    end else begin
                        if (cur_cnt != '0) begin
                            wr_cur    = 1'b1;
                            new_val   = cur_val / WIDTH'(10);
                            new_cnt   = cur_cnt - CW'(1);
                            chained_d = 1'b0;
                            pos_d     = (cur_cnt > CW'(1)) ? POS_W'(cur_cnt - CW'(2)) : '0;
                        end else if (is_b) begin
                            state_d = ENTRY_A;
                        end
                    end
                end
            end
            COMPUTE: begin
                if (op_q == OP_DIV && b_q == '0) begin
                    state_d = ERR;
                end else if (cyc_q != '0) begin
                    acc_d = mul_acc_n;
                    mc_d  = mc_q << 1;
                    mb_d  = (op_q == OP_DIV) ? div_q_n : mb_q >> 1;
                    rem_d = div_rem_n;
                    cyc_d = cyc_q - CYW'(1);
                end else if (res > LIMIT) begin
                    state_d = ERR;
                end else begin
                    r_d     = res[WIDTH-1:0];
                    bin_d   = res[WIDTH-1:0];
                    bcd_d   = '0;
                    cyc_d   = CYW'(WIDTH - 1);
                    neg_d   = (op_q == OP_SUB) && !a_ge_b;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = bcd_n;
                bin_d = bin_n;
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - CYW'(1);
                end else begin
                    state_d     = EMIT;
                    n_d         = conv_n;
                    emit_idx_d  = conv_n - CW'(1);
                    dig_d       = conv_top;
                    pos_d       = '0;
                    dig_valid_d = 1'b1;
                end
            end
            EMIT: begin
                if (emit_idx_q == '0) begin
                    state_d = ENTRY_A;
                    b_d     = '0;
                    b_cnt_d = '0;
                    // Only a non-negative result can seed the next calculation.
                    if (neg_q) begin
                        a_d       = '0;
                        a_cnt_d   = '0;
                        chained_d = 1'b0;
                    end else begin
                        a_d       = r_q;
                        a_cnt_d   = n_q;
                        chained_d = 1'b1;
                    end
                end else begin
                    emit_idx_d  = emit_idx_q - CW'(1);
                    dig_d       = emit_dig;
                    pos_d       = pos_q + POS_W'(1);
                    dig_valid_d = 1'b1;
                end
            end
            ERR: begin
                if (cmd_valid && cmd == 4'hF) begin
                    state_d   = ENTRY_A;
                    a_d       = '0;
                    b_d       = '0;
                    a_cnt_d   = '0;
                    b_cnt_d   = '0;
                    op_d      = OP_ADD;
                    chained_d = 1'b0;
                    pos_d     = '0;
                    dig_d     = '0;
                    neg_d     = 1'b0;
                end
            end
            default: state_d = ENTRY_A;
        endcase

        if (wr_cur) begin
            if (is_b) begin
                b_d     = new_val;
                b_cnt_d = new_cnt;
            end else begin
                a_d     = new_val;
                a_cnt_d = new_cnt;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ENTRY_A;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            mb_q        <= '0;
            rem_q       <= '0;
            bin_q       <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            n_q         <= '0;
            emit_idx_q  <= '0;
            op_q        <= OP_ADD;
            chained_q   <= 1'b0;
            neg_q       <= 1'b0;
            pos_q       <= '0;
            dig_q       <= '0;
            dig_valid_q <= 1'b0;
            acc_q       <= '0;
            mc_q        <= '0;
            cyc_q       <= '0;
            bcd_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            bin_q       <= bin_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            n_q         <= n_d;
            emit_idx_q  <= emit_idx_d;
            op_q        <= op_d;
            chained_q   <= chained_d;
            neg_q       <= neg_d;
            pos_q       <= pos_d;
            dig_q       <= dig_d;
            dig_valid_q <= dig_valid_d;
            acc_q       <= acc_d;
            mc_q        <= mc_d;
            cyc_q       <= cyc_d;
            bcd_q       <= bcd_d;
        end
    end

    always_comb begin
        case (state_q)
            ENTRY_A, ENTRY_B: status = 2'b01;
            ERR:              status = 2'b00;
            default:          status = 2'b10;
        endcase
    end

    assign pos       = pos_q;
    assign dig       = dig_q;
    assign dig_valid = dig_valid_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_calc_bcd_param.sv
// Bench for calc_bcd_param: directed scenarios plus random operations checked
// against a plain-arithmetic decimal calculator model.
module tb_calc_bcd_param;
    localparam int MAXD   = 8;
    localparam int W      = 32;
    localparam int PW     = 4;
    localparam int OP_ADD = 10;
    localparam int OP_SUB = 11;
    localparam int OP_MUL = 12;
    localparam int OP_DIV = 13;

    logic          clock;
    logic          reset;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [1:0]    status;
    logic [PW-1:0] pos;
    logic [3:0]    dig;
    logic          dig_valid;
    logic          neg;

    int tests_run = 0;
    int failed    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    calc_bcd_param #(.MAX_DIGITS(MAXD), .WIDTH(W), .POS_W(PW)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .status(status), .pos(pos), .dig(dig), .dig_valid(dig_valid), .neg(neg)
    );

    task automatic send(input int c);
        @(negedge clock);
        cmd       = 4'(c);
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd       = 4'd0;
    endtask

    function automatic void model(input longint a, input longint b, input int op,
                                  output bit err, output bit ng, output longint r);
        longint lim = 1;
        repeat (MAXD) lim *= 10;
        err = 1'b0;
        ng  = 1'b0;
        r   = 0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: if (a >= b) r = a - b; else begin r = b - a; ng = 1'b1; end
            OP_MUL: r = a * b;
            default: if (b == 0) err = 1'b1; else r = a / b;
        endcase
        if (r >= lim) err = 1'b1;
    endfunction

    function automatic longint rnd_num();
        longint m = 1;
        int nd = $urandom_range(1, MAXD);
        repeat (nd) m *= 10;
        return longint'($urandom) % m;
    endfunction

    task automatic enter_num(input longint v);
        int ds[$];
        longint t = v;
        do begin
            ds.push_front(int'(t % 10));
            t /= 10;
        end while (t != 0);
        foreach (ds[i]) begin
            send(ds[i]);
            tests_run++;
            if (dig_valid !== 1'b1 || dig !== 4'(ds[i]) || pos !== PW'(i)) begin
                failed++;
                $display("FAIL entry_digit: got valid=%0b dig=%0d pos=%0d, want valid=1 dig=%0d pos=%0d",
                         dig_valid, dig, pos, ds[i], i);
            end
        end
    endtask

    task automatic run_calc(input longint a, input longint b, input int op, input bit fresh_a,
                            output longint r, output bit err);
        bit     ng, ok;
        int     cyc, first, c_lat, exp_cyc;
        int     got[$];
        int     gpos[$];
        int     want[$];
        longint t, gv;
        model(a, b, op, err, ng, r);
        c_lat = (op == OP_MUL || op == OP_DIV) ? W : 1;
        if (fresh_a) enter_num(a);
        send(op);
        enter_num(b);
        send(14);
        tests_run++;
        if (status !== 2'b10) begin
            failed++;
            $display("FAIL busy_status: got %b want 10 (%0d op%0d %0d)", status, a, op, b);
        end
        cyc   = 0;
        first = -1;
        while (status === 2'b10 && cyc < 200) begin
            if (dig_valid === 1'b1) begin
                if (first < 0) first = cyc;
                got.push_back(int'(dig));
                gpos.push_back(int'(pos));
            end
            @(negedge clock);
            cyc++;
        end
        gv = 0;
        foreach (got[i]) gv = gv * 10 + got[i];
        tests_run++;
        if (cyc >= 200) begin
            failed++;
            $display("FAIL result_timeout: status still %b after %0d cycles", status, cyc);
        end else if (err) begin
            exp_cyc = (op == OP_DIV && b == 0) ? 1 : c_lat;
            if (status !== 2'b00 || cyc != exp_cyc || got.size() != 0) begin
                failed++;
                $display("FAIL err_path: %0d op%0d %0d got status=%b at cycle %0d pulses=%0d, want 00 at %0d pulses=0",
                         a, op, b, status, cyc, got.size(), exp_cyc);
            end
            send(15);
            tests_run++;
            if (status !== 2'b01 || pos !== '0 || dig !== 4'd0 || neg !== 1'b0 || dig_valid !== 1'b0) begin
                failed++;
                $display("FAIL err_clear: got status=%b pos=%0d dig=%0d neg=%0b, want 01/0/0/0",
                         status, pos, dig, neg);
            end
        end else begin
            t = r;
            do begin
                want.push_front(int'(t % 10));
                t /= 10;
            end while (t != 0);
            ok = (got.size() == want.size());
            if (ok) foreach (got[i]) if (got[i] != want[i] || gpos[i] != i) ok = 1'b0;
            if (!ok || first != c_lat + W) begin
                failed++;
                $display("FAIL result: %0d op%0d %0d got %0d (%0d digits, first at %0d), want %0d (%0d digits, first at %0d)",
                         a, op, b, gv, got.size(), first, r, want.size(), c_lat + W);
            end
            tests_run++;
            if (status !== 2'b01 || neg !== ng) begin
                failed++;
                $display("FAIL result_flags: got status=%b neg=%0b, want 01 neg=%0b", status, neg, ng);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd       = 4'd0;
        cmd_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (status !== 2'b01 || pos !== '0 || dig !== 4'd0 || dig_valid !== 1'b0 || neg !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got %b/%0d/%0d/%0b/%0b want 01/0/0/0/0", status, pos, dig, dig_valid, neg);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (status !== 2'b01 || dig_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_release: got status=%b valid=%0b want 01/0", status, dig_valid);
        end
    endtask

    task automatic test_add_chain();
        longint r;
        bit     e;
        run_calc(12, 34, OP_ADD, 1'b1, r, e);
        run_calc(r, 4, OP_SUB, 1'b0, r, e);
    endtask

    task automatic test_sub_neg();
        longint r;
        bit     e;
        run_calc(5, 9, OP_SUB, 1'b1, r, e);
        send(3);
        tests_run++;
        if (neg !== 1'b0 || dig_valid !== 1'b1 || dig !== 4'd3 || pos !== '0) begin
            failed++;
            $display("FAIL neg_clear: got neg=%0b valid=%0b dig=%0d pos=%0d want 0/1/3/0", neg, dig_valid, dig, pos);
        end
        send(15);
    endtask

    task automatic test_mul_overflow();
        longint r;
        bit     e;
        run_calc(9999, 9999, OP_MUL, 1'b1, r, e);
        run_calc(r, 2, OP_MUL, 1'b0, r, e);
    endtask

    task automatic test_div();
        longint r;
        bit     e;
        run_calc(100, 7, OP_DIV, 1'b1, r, e);
        run_calc(7, 0, OP_DIV, 1'b1, r, e);
    endtask

    task automatic test_backspace();
        longint r;
        bit     e;
        enter_num(123);
        send(15);
        tests_run++;
        if (dig_valid !== 1'b0 || pos !== PW'(1)) begin
            failed++;
            $display("FAIL backspace: got valid=%0b pos=%0d want 0/1", dig_valid, pos);
        end
        send(4);
        tests_run++;
        if (dig_valid !== 1'b1 || dig !== 4'd4 || pos !== PW'(2)) begin
            failed++;
            $display("FAIL after_backspace: got valid=%0b dig=%0d pos=%0d want 1/4/2", dig_valid, dig, pos);
        end
        run_calc(124, 1, OP_ADD, 1'b0, r, e);
        enter_num(12345678);
        send(9);
        tests_run++;
        if (status !== 2'b00 || pos !== '0 || dig_valid !== 1'b0) begin
            failed++;
            $display("FAIL ninth_digit: got status=%b pos=%0d valid=%0b want 00/0/0", status, pos, dig_valid);
        end
        send(15);
        tests_run++;
        if (status !== 2'b01) begin
            failed++;
            $display("FAIL ninth_clear: got status=%b want 01", status);
        end
    endtask

    task automatic test_reset_mid_mul();
        longint r;
        bit     e;
        enter_num(12);
        send(OP_MUL);
        enter_num(3);
        send(14);
        repeat (9) @(negedge clock);
        tests_run++;
        if (status !== 2'b10) begin
            failed++;
            $display("FAIL pre_reset_busy: got status=%b want 10", status);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (status !== 2'b01 || pos !== '0 || dig !== 4'd0 || dig_valid !== 1'b0 || neg !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset: got %b/%0d/%0d/%0b/%0b want 01/0/0/0/0", status, pos, dig, dig_valid, neg);
        end
        @(negedge clock);
        reset = 1'b1;
        enter_num(5);
        run_calc(5, 1, OP_ADD, 1'b0, r, e);
    endtask

    task automatic test_busy_drop();
        longint r;
        bit     e;
        int     cyc, npulse, lastd;
        enter_num(2);
        send(OP_MUL);
        enter_num(3);
        send(14);
        send(5);
        send(15);
        send(OP_ADD);
        cyc    = 0;
        npulse = 0;
        lastd  = -1;
        while (status === 2'b10 && cyc < 200) begin
            if (dig_valid === 1'b1) begin
                npulse++;
                lastd = int'(dig);
            end
            @(negedge clock);
            cyc++;
        end
        tests_run++;
        if (npulse != 1 || lastd != 6 || status !== 2'b01) begin
            failed++;
            $display("FAIL busy_drop: got %0d pulses last=%0d status=%b want 1 pulse 6 status 01",
                     npulse, lastd, status);
        end
        run_calc(6, 1, OP_ADD, 1'b0, r, e);
    endtask

    task automatic test_random();
        longint a, b, r;
        bit     e, ng, dummy_e;
        int     op;
        for (int k = 0; k < 30; k++) begin
            a  = rnd_num();
            b  = ($urandom_range(0, 7) == 0) ? 0 : rnd_num();
            op = $urandom_range(OP_ADD, OP_DIV);
            run_calc(a, b, op, 1'b1, r, e);
            model(a, b, op, dummy_e, ng, r);
            if (!e && !ng && $urandom_range(0, 1) == 1) begin
                run_calc(r, longint'($urandom_range(0, 999)), $urandom_range(OP_ADD, OP_DIV), 1'b0, r, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_chain();
        test_sub_neg();
        test_mul_overflow();
        test_div();
        test_backspace();
        test_reset_mid_mul();
        test_busy_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not complete, %0d tests run", tests_run);
        $fatal(1);
    end

endmodule
